// File: rtl/cpu_core_params.sv
// Core-wide data types shared by the CPU execution units.
package cpu_core_params;

    typedef logic [31:0] CpuData;

endpackage

// File: rtl/divider_params.sv
// Types, constants and helpers for the iterative integer divider.
package divider_params;

    import cpu_core_params::CpuData;

    localparam int DIV_ITERATIONS = 32;
    localparam int DIV_COUNT_W    = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

    // Quotient lands in LO, remainder in HI.
    typedef struct packed {
        CpuData quotient;
        CpuData remainder;
    } DivideResultData;

    function automatic CpuData magnitude(input CpuData value, input logic is_signed);
        return (is_signed && value[31]) ? -value : value;
    endfunction

endpackage

// File: rtl/divider_step.sv
// One radix-2 restoring division step: shift in the next dividend bit,
// trial-subtract the divisor, keep the difference if it did not borrow.
module divider_step (
    input  logic [32:0] rem_in,
    input  logic [31:0] quo_in,
    input  logic [31:0] divisor,
    output logic [32:0] rem_out,
    output logic [31:0] quo_out
);

    logic [32:0] shifted;
    logic [33:0] trial;
    logic        fits;

    assign shifted = {rem_in[31:0], quo_in[31]};
    assign trial   = {1'b0, shifted} - {2'b00, divisor};
    // A set top bit means the partial remainder already exceeds any 32-bit divisor.
    assign fits    = rem_in[32] | ~trial[33];

    assign rem_out = fits ? trial[32:0] : shifted;
    assign quo_out = {quo_in[30:0], fits};

endmodule

// File: rtl/divider.sv
// Multi-cycle 32-bit DIV/DIVU unit: valid/ready operand and result handshakes,
// fixed 33-edge latency, flush abandons the operation without touching result.
module divider
    import cpu_core_params::*;
    import divider_params::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  CpuData          input1,
    input  CpuData          input2,
    input  logic            is_signed,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output DivideResultData result
);

    div_state_e             state_reg, state_next;
    logic [DIV_COUNT_W-1:0] count_reg;
    logic [32:0]            rem_reg;
    CpuData                 quo_reg;
    CpuData                 divisor_reg;
    CpuData                 dividend_reg;
    logic                   sign_a_reg, sign_b_reg, signed_reg, div_zero_reg;
    DivideResultData        result_reg, result_next;

    logic        accept, finish, count_done;
    logic [32:0] step_rem;
    CpuData      step_quo;

    assign count_done = (count_reg == DIV_COUNT_W'(DIV_ITERATIONS));

    divider_step u_step (
        .rem_in  (rem_reg),
        .quo_in  (quo_reg),
        .divisor (divisor_reg),
        .rem_out (step_rem),
        .quo_out (step_quo)
    );

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        finish     = 1'b0;
        case (state_reg)
            IDLE: if (in_valid) begin
                state_next = CALC;
                accept     = 1'b1;
            end
            CALC: if (count_done) begin
                state_next = DONE;
                finish     = 1'b1;
            end
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush) begin
            state_next = IDLE;
            accept     = 1'b0;
            finish     = 1'b0;
        end
    end

    // Divide-by-zero bypasses sign fix-up so the remainder is the raw dividend.
    always_comb begin
        result_next.quotient  = (signed_reg && (sign_a_reg ^ sign_b_reg)) ? -quo_reg : quo_reg;
        result_next.remainder = (signed_reg && sign_a_reg) ? -rem_reg[31:0] : rem_reg[31:0];
        if (div_zero_reg) begin
            result_next.quotient  = '1;
            result_next.remainder = dividend_reg;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            count_reg    <= '0;
            rem_reg      <= '0;
            quo_reg      <= '0;
            divisor_reg  <= '0;
            dividend_reg <= '0;
            sign_a_reg   <= 1'b0;
            sign_b_reg   <= 1'b0;
            signed_reg   <= 1'b0;
            div_zero_reg <= 1'b0;
            result_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                count_reg    <= '0;
                rem_reg      <= '0;
                quo_reg      <= magnitude(input1, is_signed);
                divisor_reg  <= magnitude(input2, is_signed);
                dividend_reg <= input1;
                sign_a_reg   <= input1[31];
                sign_b_reg   <= input2[31];
                signed_reg   <= is_signed;
                div_zero_reg <= (input2 == '0);
            end else if (state_reg == CALC && !count_done) begin
                count_reg <= count_reg + DIV_COUNT_W'(1);
                rem_reg   <= step_rem;
                quo_reg   <= step_quo;
            end
            if (finish) result_reg <= result_next;
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign result    = result_reg;

endmodule

// File: tb/tb_divider.sv
// Directed bench for divider: vector table plus flush, hold and reset sequences.
module tb_divider;
    import cpu_core_params::*;
    import divider_params::*;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    CpuData          input1 = '0;
    CpuData          input2 = '0;
    logic            is_signed = 1'b0;
    logic            flush = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    DivideResultData result;

    int tests  = 0;
    int failed = 0;

    divider dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .input1    (input1),
        .input2    (input2),
        .is_signed (is_signed),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string  name;
        logic   sgn;
        CpuData a;
        CpuData b;
        CpuData exp_q;
        CpuData exp_r;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Drive operands on the current negedge; accept happens on the next posedge.
    task automatic start_op(input logic sgn, input CpuData a, input CpuData b);
        in_valid  = 1'b1;
        is_signed = sgn;
        input1    = a;
        input2    = b;
        @(posedge clock);
        #1;
        in_valid  = 1'b0;
        input1    = ~a;
        input2    = b + 32'd5;
        is_signed = ~sgn;
    endtask

    task automatic wait_done(input string name, input CpuData eq, input CpuData er,
                             input DivideResultData prev);
        int  lat = 0;
        logic stable = 1'b1;
        check({name, " accepted"}, {31'd0, in_ready}, 32'd0);
        for (int n = 1; n <= 40; n++) begin
            @(posedge clock);
            #1;
            if (out_valid) begin
                lat = n;
                break;
            end
            if (result !== prev) stable = 1'b0;
        end
        check({name, " latency"}, lat, 32'd33);
        check({name, " result held during CALC"}, {31'd0, stable}, 32'd1);
        check({name, " quotient"}, result.quotient, eq);
        check({name, " remainder"}, result.remainder, er);
        $display("[TB] %s: q=%h r=%h latency=%0d", name, result.quotient, result.remainder, lat);
    endtask

    // Handoff edge with in_valid high: the same edge must not accept.
    task automatic handoff(input string name);
        @(negedge clock);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check({name, " handoff out_valid"}, {31'd0, out_valid}, 32'd0);
        check({name, " handoff no accept"}, {31'd0, in_ready}, 32'd1);
    endtask

    task automatic run_op(input string name, input logic sgn, input CpuData a, input CpuData b,
                          input CpuData eq, input CpuData er);
        DivideResultData prev;
        prev = result;
        @(negedge clock);
        start_op(sgn, a, b);
        wait_done(name, eq, er, prev);
        handoff(name);
    endtask

    vec_t vecs[10];

    initial begin
        DivideResultData prev;
        logic saw_valid;

        vecs[0] = '{"DIVU 100/7",        1'b0, 32'd100,        32'd7,          32'd14,         32'd2};
        vecs[1] = '{"DIV -7/2",          1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF};
        vecs[2] = '{"DIVU 0xFFFFFFF9/2", 1'b0, 32'hFFFFFFF9,   32'd2,          32'h7FFFFFFC,   32'd1};
        vecs[3] = '{"DIV overflow",      1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0};
        vecs[4] = '{"DIVU 1234/0",       1'b0, 32'd1234,       32'd0,          32'hFFFFFFFF,   32'd1234};
        vecs[5] = '{"DIV -256/0",        1'b1, 32'hFFFFFF00,   32'd0,          32'hFFFFFFFF,   32'hFFFFFF00};
        vecs[6] = '{"DIV 7/-2",          1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1};
        vecs[7] = '{"DIVU max/1",        1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0};
        vecs[8] = '{"DIV 100/-7",        1'b1, 32'd100,        32'hFFFFFFF9,   32'hFFFFFFF2,   32'd2};
        vecs[9] = '{"DIV -100/-7",       1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE};

        #3;
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset in_ready", {31'd0, in_ready}, 32'd1);
        check("reset result q", result.quotient, 32'd0);
        check("reset result r", result.remainder, 32'd0);
        @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < 10; i++)
            run_op(vecs[i].name, vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp_q, vecs[i].exp_r);

        // Flush at CALC step 10, then an immediate 9/3.
        prev = result;
        @(negedge clock);
        start_op(1'b0, 32'd50, 32'd5);
        repeat (10) @(posedge clock);
        @(negedge clock);
        flush = 1'b1;
        @(posedge clock);
        #1;
        flush = 1'b0;
        check("flush out_valid", {31'd0, out_valid}, 32'd0);
        check("flush in_ready", {31'd0, in_ready}, 32'd1);
        check("flush result q kept", result.quotient, prev.quotient);
        check("flush result r kept", result.remainder, prev.remainder);
        $display("[TB] flushed DIVU 50/5 at step 10");
        run_op("DIVU 9/3 after flush", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0);

        // Hold in DONE for 5 cycles, then reset in the middle of a second op.
        prev = result;
        @(negedge clock);
        start_op(1'b0, 32'd1000, 32'd10);
        wait_done("DIVU 1000/10 hold", 32'd100, 32'd0, prev);
        for (int c = 0; c < 5; c++) begin
            @(posedge clock);
            #1;
            check("hold out_valid", {31'd0, out_valid}, 32'd1);
            check("hold in_ready", {31'd0, in_ready}, 32'd0);
            check("hold quotient", result.quotient, 32'd100);
        end
        $display("[TB] held result 5 cycles with out_ready low");
        handoff("DIVU 1000/10 hold");
        @(negedge clock);
        start_op(1'b1, 32'hFFFFFF9C, 32'd3);
        repeat (15) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("async reset out_valid", {31'd0, out_valid}, 32'd0);
        check("async reset result q", result.quotient, 32'd0);
        check("async reset result r", result.remainder, 32'd0);
        check("async reset in_ready", {31'd0, in_ready}, 32'd1);
        $display("[TB] reset asserted mid-CALC");
        @(negedge clock);
        reset = 1'b1;
        saw_valid = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clock);
            #1;
            if (out_valid) saw_valid = 1'b1;
        end
        check("no result after reset", {31'd0, saw_valid}, 32'd0);
        check("idle after reset result q", result.quotient, 32'd0);

        // Accept on the very first edge after reset release.
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        prev = result;
        start_op(1'b0, 32'd77, 32'd8);
        wait_done("DIVU 77/8 first edge", 32'd9, 32'd5, prev);
        handoff("DIVU 77/8 first edge");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/divider.md
DIVIDER -- requirements
Module: divider

Interface
REQ-001 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port in_valid, input, 1, operands present on input1/input2/is_signed.
REQ-004 SHALL have port in_ready, output, 1, divider can accept operands.
REQ-005 SHALL have port input1, input, cpu_core_params::CpuData (32), dividend.
REQ-006 SHALL have port input2, input, cpu_core_params::CpuData (32), divisor.
REQ-007 SHALL have port is_signed, input, 1, 1 = DIV, 0 = DIVU.
REQ-008 SHALL have port flush, input, 1, abandon any operation in progress.
REQ-009 SHALL have port out_valid, output, 1, result holds a finished quotient and remainder.
REQ-010 SHALL have port out_ready, input, 1, consumer (HI/LO write) takes the result.
REQ-011 SHALL have port result, output, divider_params::DivideResultData, {quotient (LO), remainder (HI)}, 32 bits each.

Function
REQ-012 SHALL implement states IDLE, CALC and DONE.
REQ-013 SHALL drive in_ready=1 only in IDLE and out_valid=1 only in DONE.
REQ-014 SHALL accept operands on a rising edge with in_valid&in_ready, latch operand magnitudes, operand signs and is_signed, and enter CALC.
REQ-015 SHALL ignore input1/input2/is_signed changes after the accept edge.
REQ-016 SHALL perform one radix-2 restoring step per CALC cycle on the 32-bit magnitudes (partial remainder 33 bits wide), using a 6-bit iteration counter.
REQ-017 SHALL run exactly 32 steps in CALC, then enter DONE on the next edge; out_valid first observes high 33 edges after the accept edge, independent of operand values.
REQ-018 SHALL take magnitudes as two's-complement absolute values when is_signed=1 and operand bit 31 is set, and raw operand values otherwise.
REQ-019 SHALL negate the final quotient when is_signed=1 and the operand signs differ, and negate the final remainder when is_signed=1 and the dividend is negative; remainder sign always equals dividend sign.
REQ-020 SHALL, in the signed-overflow case 0x80000000 / 0xFFFFFFFF, return quotient 0x80000000 and remainder 0 (natural wrap, no flag).
REQ-021 SHALL, on divide-by-zero, complete with the normal 33-edge latency and return quotient 0xFFFFFFFF and remainder equal to input1, regardless of is_signed.
REQ-022 SHALL hold result and out_valid stable in DONE while out_ready=0, and move DONE->IDLE on an edge with out_ready=1.
REQ-023 SHALL accept no new operation in the same cycle as the DONE->IDLE handoff; back-to-back throughput is one divide per 35 cycles.
REQ-024 SHALL return to IDLE on the next edge when flush=1, from any state; flush has priority over accept and handoff; out_valid is 0 the cycle after.
REQ-025 SHALL not update result after a flushed operation, so result retains its previous value.

Reset
REQ-026 SHALL, while reset=0, force state IDLE, iteration counter 0, result 0, out_valid 0, in_ready 1 and all internal registers 0, asynchronously.
REQ-027 SHALL discard any operation in progress when reset is asserted mid-operation, with no partial result emitted after release.
REQ-028 SHALL allow an accept on the first rising edge after reset deasserts.

Structure
REQ-029 SHALL place DivideResultData (packed struct: quotient, remainder) and the DIV_ITERATIONS=32 constant in package divider_params, alongside multiplier_params.
REQ-030 SHALL implement one iteration (33-bit trial subtract, select, shift, quotient bit) as a combinational sub-module divider_step instantiated once.

Verification
REQ-031 SHALL cover DIVU 100 / 7 -> quotient 14, remainder 2; out_valid at edge 33 after accept.
REQ-032 SHALL cover DIV 0xFFFFFFF9 (-7) / 2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; the same operands as DIVU -> quotient 0x7FFFFFFC, remainder 1.
REQ-033 SHALL cover DIV 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0.
REQ-034 SHALL cover DIVU 1234 / 0 and DIV 0xFFFFFF00 / 0 -> quotient 0xFFFFFFFF, remainder equal to the dividend, both at 33-edge latency.
REQ-035 SHALL cover flush at CALC step 10, then an immediate DIVU 9/3 -> no out_valid for the flushed op; 9/3 returns 3, 0; result unchanged in between.
REQ-036 SHALL cover out_ready held 0 for 5 cycles in DONE, then reset asserted mid-CALC of a second op -> result stable and in_ready 0 during the hold; after reset, out_valid 0, result 0, in_ready 1.
